dsp_adder32: RTL and testbench
==============================

# dsp_adder32

Registered 32-bit unsigned/two's-complement adder for the new processor core, built the way the iCE40 SB_MAC16 DSP accumulator adds: two 16-bit halves with a carry chain between them. The sum is computed in one combinational pass and captured in an output register on the rising clock edge. It serves as the core's general-purpose add path (ALU add, PC and branch-target arithmetic) wherever a single cycle of latency is acceptable. The module is instantiated as `dsp_adder`.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- input1  input  32  addend A.
- input2  input  32  addend B.
- out  output  32  registered sum, `(input1 + input2) mod 2^32`.
- carry_out  output  1  registered carry out of bit 31. May be left unconnected.

## Operation
- The low half is computed as `lo = input1[15:0] + input2[15:0]`, giving a 17-bit result.
  - `lo[16]` is the carry into the high half.
- The high half is computed as `hi = input1[31:16] + input2[31:16] + lo[16]`, giving a 17-bit result.
- The next-state sum is `{hi[15:0], lo[15:0]}`, and the next-state carry is `hi[16]`.
- Wrap-around: any overflow past bit 31 is discarded from `out` and reported only through `carry_out`. No saturation.
- Signed and unsigned operands give the same bit pattern in `out`. Signed overflow is not flagged.
- The block has no enable and no handshake. A new operand pair is accepted every cycle.

## Timing
- Latency is 1 cycle: operands present before rising edge N appear on `out`/`carry_out` after edge N.
- Throughput is one add per cycle. Back-to-back operand changes produce back-to-back results with no bubbles.
- Reset behaviour:
  - When `reset=1` at a rising edge, `out` ← 32'd0 and `carry_out` ← 0, regardless of the inputs.
  - Reset has priority over the add.
- Reset mid-stream: the result whose operands were sampled at the reset edge is lost. The first edge with `reset=0` captures the current operands normally.
- Outputs hold their last value while the inputs are stable. There is no spurious update without a clock edge.
- Before the first reset, output values are undefined. The bench must apply reset for at least one cycle.
- Combinational depth is one 16-bit add plus one 16-bit add with carry-in. Both must close timing at the core clock.

## Structure
- A shared package (core-wide arithmetic package) holds two constants:
  - `ADDER_WIDTH = 32`
  - `ADDER_HALF = 16`
- One sub-module is natural: `dsp_add16`.
  - Inputs: two 16-bit operands and a carry-in.
  - Outputs: a 16-bit sum and a carry-out. Purely combinational.
  - Instantiate it twice, with the low half's carry-out wired to the high half's carry-in.
- The top level contains only the two `dsp_add16` instances and the output register with its synchronous reset.

## Test plan
- Reset:
  - Hold reset for 2 cycles with inputs `0xFFFFFFFF` / `0x00000001` → `out=0` and `carry_out=0` during and immediately after reset.
  - Release reset → `out=0`, `carry_out=1` one cycle later.
- Basic sequence, one pair per cycle → each result appears exactly 1 cycle later, with `carry_out=0` throughout:

| input1 | input2 | out |
|---|---|---|
| 0 | 0 | 0 |
| 0 | 10 | 10 |
| 1000 | 10 | 1010 |
| 10230 | 1602 | 11832 |
| 13413 | 12823 | 26236 |
| 151 | 153321 | 153472 |

- Half-boundary carry:
  - `0x0000FFFF` + `0x00000001` → `out=0x00010000`, `carry_out=0`.
  - `0x7FFFFFFF` + `0x00000001` → `out=0x80000000`, `carry_out=0`.
- Full wrap: `0xFFFFFFFF` + `0xFFFFFFFF` → `out=0xFFFFFFFE`, `carry_out=1`.
- Reset mid-stream:
  - Stream 1+1, 2+2, 3+3 and assert reset on the edge that samples 2+2 → `out` sequence is 2, 0, 6.
- Hold: keep inputs at 5+7 for 4 cycles → `out` stays at 12 with no glitches on any clock edge.

Source files
------------

// File: rtl/dsp_adder32_pkg.sv
// Core-wide arithmetic constants shared by the split-carry adder and its halves.
package dsp_adder32_pkg;

  // Full operand width of the adder datapath.
  localparam int ADDER_WIDTH = 32;

  // Width of one half of the carry-chained datapath.
  localparam int ADDER_HALF = 16;

endpackage : dsp_adder32_pkg

// File: rtl/dsp_add16.sv
// One 16-bit slice of the adder: purely combinational sum with carry in/out,
// mirroring the two-half carry chain of an iCE40 DSP accumulator.
module dsp_add16
  import dsp_adder32_pkg::*;
(
  input  logic [ADDER_HALF-1:0] a,
  input  logic [ADDER_HALF-1:0] b,
  input  logic                  carry_in,
  output logic [ADDER_HALF-1:0] sum,
  output logic                  carry_out
);

  // Widened sum; the extra top bit is the carry out of this slice.
  logic [ADDER_HALF:0] full_s;

  assign full_s    = {1'b0, a} + {1'b0, b} + {{ADDER_HALF{1'b0}}, carry_in};
  assign sum       = full_s[ADDER_HALF-1:0];
  assign carry_out = full_s[ADDER_HALF];

endmodule : dsp_add16

// File: rtl/dsp_adder32.sv
// Registered 32-bit adder built from two 16-bit slices joined by a carry chain.
// One cycle of latency, one add per cycle, synchronous active-high reset.
module dsp_adder32
  import dsp_adder32_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDER_WIDTH-1:0] input1,
  input  logic [ADDER_WIDTH-1:0] input2,
  output logic [ADDER_WIDTH-1:0] out,
  output logic                   carry_out
);

  logic [ADDER_HALF-1:0] lo_sum_s;
  logic [ADDER_HALF-1:0] hi_sum_s;
  logic                  lo_carry_s;
  logic                  hi_carry_s;

  // Low half: no carry in, its carry out feeds the high half.
  dsp_add16 u_lo (
    .a         (input1[ADDER_HALF-1:0]),
    .b         (input2[ADDER_HALF-1:0]),
    .carry_in  (1'b0),
    .sum       (lo_sum_s),
    .carry_out (lo_carry_s)
  );

  // High half: its carry out is the carry out of bit 31.
  dsp_add16 u_hi (
    .a         (input1[ADDER_WIDTH-1:ADDER_HALF]),
    .b         (input2[ADDER_WIDTH-1:ADDER_HALF]),
    .carry_in  (lo_carry_s),
    .sum       (hi_sum_s),
    .carry_out (hi_carry_s)
  );

  // Output register: reset clears sum and carry, otherwise capture the new sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= {ADDER_WIDTH{1'b0}};
      carry_out <= 1'b0;
    end else begin
      out       <= {hi_sum_s, lo_sum_s};
      carry_out <= hi_carry_s;
    end
  end

endmodule : dsp_adder32

// File: tb/tb_dsp_adder32.sv
// Self-checking bench for dsp_adder32: directed cases from the test plan plus
// randomized operands checked against a plain 33-bit arithmetic reference.
module tb_dsp_adder32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  dsp_adder32 dsp_adder (
    .clk       (clk),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .out       (out),
    .carry_out (carry_out)
  );

  // Free-running core clock, period 10.
  always #5 clk = ~clk;

  // Compare both outputs against the required values.
  task automatic chk(input string tag, input logic [31:0] exp_out, input logic exp_c);
    checks++;
    assert (out === exp_out) else begin
      errors++;
      $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
    end
    checks++;
    assert (carry_out === exp_c) else begin
      errors++;
      $error("FAIL %s carry_out: got %b expected %b", tag, carry_out, exp_c);
    end
  endtask

  // Reference: operands summed as plain 33-bit numbers, reset wins.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic rst,
                       output logic [31:0] e_out, output logic e_c);
    logic [32:0] wide;
    wide  = {1'b0, a} + {1'b0, b};
    e_out = rst ? 32'd0 : wide[31:0];
    e_c   = rst ? 1'b0 : wide[32];
  endtask

  // Apply one operand pair across one rising edge, then check just after it.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic rst);
    logic [31:0] e_out;
    logic        e_c;
    input1 = a;
    input2 = b;
    reset  = rst;
    model(a, b, rst, e_out, e_c);
    @(posedge clk);
    #1;
    chk(tag, e_out, e_c);
  endtask

  logic [31:0] hold_val;

  initial begin
    reset  = 1'b1;
    input1 = 32'hFFFF_FFFF;
    input2 = 32'h0000_0001;

    // Reset for two cycles with operands that would carry out.
    @(negedge clk);
    step("reset_c1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    step("reset_c2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    // Release: first unreset edge captures the current operands.
    input1 = 32'hFFFF_FFFF;
    input2 = 32'h0000_0001;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", 32'd0, 1'b1);

    // Basic table, one pair per cycle, expected values from the test plan.
    step("basic0", 32'd0, 32'd0, 1'b0);
    checks++;
    assert (out === 32'd0) else begin errors++; $error("FAIL basic0_const got %0d expected 0", out); end
    step("basic1", 32'd0, 32'd10, 1'b0);
    checks++;
    assert (out === 32'd10) else begin errors++; $error("FAIL basic1_const got %0d expected 10", out); end
    step("basic2", 32'd1000, 32'd10, 1'b0);
    checks++;
    assert (out === 32'd1010) else begin errors++; $error("FAIL basic2_const got %0d expected 1010", out); end
    step("basic3", 32'd10230, 32'd1602, 1'b0);
    checks++;
    assert (out === 32'd11832) else begin errors++; $error("FAIL basic3_const got %0d expected 11832", out); end
    step("basic4", 32'd13413, 32'd12823, 1'b0);
    checks++;
    assert (out === 32'd26236) else begin errors++; $error("FAIL basic4_const got %0d expected 26236", out); end
    step("basic5", 32'd151, 32'd153321, 1'b0);
    checks++;
    assert (out === 32'd153472) else begin errors++; $error("FAIL basic5_const got %0d expected 153472", out); end

    // Carry across the half boundary, into bit 31, and full wrap.
    step("half_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    checks++;
    assert (out === 32'h0001_0000) else begin errors++; $error("FAIL half_carry_const got %h expected 00010000", out); end
    step("to_bit31", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    checks++;
    assert (out === 32'h8000_0000) else begin errors++; $error("FAIL to_bit31_const got %h expected 80000000", out); end
    step("full_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checks++;
    assert (out === 32'hFFFF_FFFE && carry_out === 1'b1) else begin
      errors++; $error("FAIL full_wrap_const got %h/%b expected fffffffe/1", out, carry_out);
    end

    // Reset mid-stream: expected out sequence 2, 0, 6.
    step("mid_1", 32'd1, 32'd1, 1'b0);
    step("mid_2", 32'd2, 32'd2, 1'b1);
    step("mid_3", 32'd3, 32'd3, 1'b0);

    // Hold operands for four cycles; also look between edges for glitches.
    for (int i = 0; i < 4; i++) begin
      step("hold_edge", 32'd5, 32'd7, 1'b0);
      #3;
      chk("hold_mid", 32'd12, 1'b0);
    end
    hold_val = out;
    #20;
    checks++;
    assert (out === hold_val) else begin errors++; $error("FAIL hold_still got %h expected %h", out, hold_val); end

    // Randomized operands with occasional reset, back to back.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = {16'h0000, ra[15:0]} | 32'h0000_FFFF;
        1: rb = 32'hFFFF_FFFF - ra + 32'($urandom_range(0, 2));
        default: ;
      endcase
      step("random", ra, rb, ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dsp_adder32
